alu_op_scheduler: RTL and testbench
===================================

Name: alu_op_scheduler

Overview:
Shares one 64-bit ALU (with its 4-bit ALU control input) between two requesters.
- Accepts operation requests carrying an 11-bit R-format opcode field plus A/B operands.
- Arbitrates round-robin between the two requesters.
- Decodes the opcode to ALU control, sequences the ALU for ALU_LAT cycles, captures result and zero flag, and returns a tagged response under valid/ready backpressure.
- Sits between the issue logic and the ALU datapath.

Parameters:
DATA_W, 64, operand/result width.
ALU_LAT, 1, cycles the ALU inputs are held before result/zero are sampled (legal range 1..15).

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
req0_valid  input  1  requester 0 has an operation.
req0_ready  output  1  requester 0 operation accepted this cycle.
req0_opcode  input  11  requester 0 opcode field.
req0_a  input  DATA_W  requester 0 operand A.
req0_b  input  DATA_W  requester 0 operand B.
req1_valid, req1_ready, req1_opcode, req1_a, req1_b: same as requester 0, for requester 1.
alu_ctl  output  4  ALU control to shared ALU.
alu_a  output  DATA_W  ALU operand A.
alu_b  output  DATA_W  ALU operand B.
alu_result  input  DATA_W  ALU result.
alu_zero  input  1  ALU zero flag.
rsp_valid  output  1  response available.
rsp_ready  input  1  consumer takes response.
rsp_id  output  1  requester index of the response.
rsp_result  output  DATA_W  captured result.
rsp_zero  output  1  captured zero flag.
rsp_illegal  output  1  opcode not decodable.
busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values:
  - all outputs 0; alu_ctl=4'b0000.
  - operand/tag registers 0; latency counter 0.
  - round-robin pointer favours req0.
- Decode (exact match on all 11 bits):
  - 10001010000 AND -> 0000
  - 10101010000 ORR -> 0001
  - 10001011000 ADD -> 0010
  - 11001011000 SUB -> 0110
  - 11111000010 pass-B -> 0111
  - 11101010000 NOR -> 1100
  - any other value is illegal.
- IDLE:
  - reqN_ready is combinational: high only in IDLE, for the granted requester whose valid is high.
  - If only one valid: grant it.
  - If both valid: grant the one not granted last (pointer).
  - On acceptance, latch opcode, A, B and id; flip the pointer to the other requester.
  - Legal opcode -> EXEC with counter=ALU_LAT-1. Illegal opcode -> RESP.
  - No valid -> stay; both readies low.
- EXEC:
  - alu_ctl = decoded code, alu_a/alu_b = latched operands, stable for ALU_LAT cycles.
  - Counter decrements each cycle.
  - On the cycle the counter is 0: register alu_result -> rsp_result and alu_zero -> rsp_zero, rsp_illegal=0, then go to RESP.
  - Request valids are ignored; readies stay low.
- Outside EXEC:
  - alu_ctl=0000.
  - alu_a/alu_b hold the last latched operands.
- RESP:
  - rsp_valid=1; rsp_id/result/zero/illegal are stable until rsp_ready is high.
  - On rsp_valid&&rsp_ready -> IDLE, rsp_valid drops next cycle.
  - Illegal response: rsp_result=0, rsp_zero=0, rsp_illegal=1.
- Latency:
  - Legal op: accept at cycle T, rsp_valid at T+ALU_LAT+1.
  - Illegal op: rsp_valid at T+1.
  - Max throughput is one op per ALU_LAT+2 cycles with rsp_ready tied high.
  - No acceptance in the same cycle as a response handshake.
- Requester valid dropping before grant: no effect, no grant recorded.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; the in-flight op is discarded with no response.
- Pointer changes only on acceptance.

Test Plan:
- Reset, ALU_LAT=1:
  - Stimulus: req0 ADD, A=5, B=3; ALU model returns 8.
  - Required: req0_ready high 1 cycle; alu_ctl=0010 for 1 cycle; rsp_valid 2 cycles after accept, rsp_id=0, rsp_result=8, rsp_zero=0.
- Both valid, four ops each, rsp_ready=1:
  - Required: grants alternate 0,1,0,1,...; AND of A=5555555555555555, B=AAAAAAAAAAAAAAAA returns result 0, zero=1.
- Illegal opcode 00000000000 on req1:
  - Required: no EXEC (alu_ctl stays 0000); rsp_valid 1 cycle after accept, rsp_illegal=1, result 0, rsp_id=1.
- ALU_LAT=3, SUB A=10, B=10:
  - Required: alu_ctl=0110 for exactly 3 cycles; response result 0, zero=1.
- rsp_ready held low for 5 cycles during RESP with req0 valid:
  - Required: response fields stable; req0_ready stays low until 1 cycle after the rsp handshake.
- Deassert reset_n during EXEC:
  - Required: busy, rsp_valid and alu_ctl go to 0 immediately; after release, a new req1 ORR (5 | A) returns F.

Source files
------------

// File: rtl/alu_op_scheduler.sv
// Shares one ALU between two requesters: round-robin grant, opcode decode,
// ALU_LAT-cycle sequencing and a tagged valid/ready response.
module alu_op_scheduler #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [10:0]       req0_opcode,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [10:0]       req1_opcode,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [3:0]        alu_ctl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_illegal,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e            state_q, state_d;
    logic              prio_q, prio_d;   // requester favoured when both are valid
    logic [10:0]       op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              id_q, id_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              zero_q, zero_d, ill_q, ill_d;

    logic              grant;
    logic [10:0]       in_op;
    logic [DATA_W-1:0] in_a, in_b;

    function automatic logic [3:0] ctl_of(input logic [10:0] op);
        case (op)
            11'b10001010000: ctl_of = 4'b0000;
            11'b10101010000: ctl_of = 4'b0001;
            11'b10001011000: ctl_of = 4'b0010;
            11'b11001011000: ctl_of = 4'b0110;
            11'b11111000010: ctl_of = 4'b0111;
            11'b11101010000: ctl_of = 4'b1100;
            default:         ctl_of = 4'b0000;
        endcase
    endfunction

    function automatic logic is_legal(input logic [10:0] op);
        case (op)
            11'b10001010000, 11'b10101010000, 11'b10001011000,
            11'b11001011000, 11'b11111000010, 11'b11101010000: is_legal = 1'b1;
            default:                                           is_legal = 1'b0;
        endcase
    endfunction

    assign grant = (req0_valid && req1_valid) ? prio_q : req1_valid;
    assign in_op = grant ? req1_opcode : req0_opcode;
    assign in_a  = grant ? req1_a : req0_a;
    assign in_b  = grant ? req1_b : req0_b;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        zero_d     = zero_q;
        ill_d      = ill_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_ctl    = 4'b0000;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready = !grant;
                    req1_ready = grant;
                    prio_d     = !grant;
                    op_d       = in_op;
                    a_d        = in_a;
                    b_d        = in_b;
                    id_d       = grant;
                    if (is_legal(in_op)) begin
                        cnt_d   = 4'(ALU_LAT - 1);
                        state_d = EXEC;
                    end else begin
                        res_d   = '0;
                        zero_d  = 1'b0;
                        ill_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            EXEC: begin
                alu_ctl = ctl_of(op_q);
                if (cnt_q == 4'd0) begin
                    res_d   = alu_result;
                    zero_d  = alu_zero;
                    ill_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign rsp_valid   = (state_q == RESP);
    assign busy        = (state_q != IDLE);
    assign rsp_id      = id_q;
    assign rsp_result  = res_q;
    assign rsp_zero    = zero_q;
    assign rsp_illegal = ill_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: two instances (ALU_LAT 1 and 3) each driving a
// behavioural ALU; directed vectors, corner sequences and a random model check.
module tb_alu_op_scheduler;

    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;
    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_PSB = 11'b11111000010;
    localparam logic [10:0] OP_NOR = 11'b11101010000;

    typedef struct {
        int          inst;
        logic        id;
        logic [10:0] op;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  ctl;
        logic [63:0] res;
        logic        zero;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid[2], req1_valid[2], req0_ready[2], req1_ready[2];
    logic [10:0] req0_opcode[2], req1_opcode[2];
    logic [63:0] req0_a[2], req0_b[2], req1_a[2], req1_b[2];
    logic [63:0] alu_a[2], alu_b[2], alu_result[2], rsp_result[2];
    logic [3:0]  alu_ctl[2];
    logic        alu_zero[2], rsp_valid[2], rsp_ready[2], rsp_id[2];
    logic        rsp_zero[2], rsp_illegal[2], busy[2];

    int checks = 0;
    int errors = 0;
    logic [10:0] legal_ops[6];
    vec_t vecs[9];

    always #5 clk = ~clk;

    alu_op_scheduler #(.DATA_W(64), .ALU_LAT(1)) u_lat1 (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid[0]), .req0_ready(req0_ready[0]), .req0_opcode(req0_opcode[0]),
        .req0_a(req0_a[0]), .req0_b(req0_b[0]),
        .req1_valid(req1_valid[0]), .req1_ready(req1_ready[0]), .req1_opcode(req1_opcode[0]),
        .req1_a(req1_a[0]), .req1_b(req1_b[0]),
        .alu_ctl(alu_ctl[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
        .alu_result(alu_result[0]), .alu_zero(alu_zero[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_id(rsp_id[0]),
        .rsp_result(rsp_result[0]), .rsp_zero(rsp_zero[0]), .rsp_illegal(rsp_illegal[0]),
        .busy(busy[0])
    );

    alu_op_scheduler #(.DATA_W(64), .ALU_LAT(3)) u_lat3 (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid[1]), .req0_ready(req0_ready[1]), .req0_opcode(req0_opcode[1]),
        .req0_a(req0_a[1]), .req0_b(req0_b[1]),
        .req1_valid(req1_valid[1]), .req1_ready(req1_ready[1]), .req1_opcode(req1_opcode[1]),
        .req1_a(req1_a[1]), .req1_b(req1_b[1]),
        .alu_ctl(alu_ctl[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
        .alu_result(alu_result[1]), .alu_zero(alu_zero[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_id(rsp_id[1]),
        .rsp_result(rsp_result[1]), .rsp_zero(rsp_zero[1]), .rsp_illegal(rsp_illegal[1]),
        .busy(busy[1])
    );

    // Shared ALU behaviour as seen through the 4-bit control code.
    function automatic logic [63:0] alu_fn(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
        case (c)
            4'b0000: alu_fn = a & b;
            4'b0001: alu_fn = a | b;
            4'b0010: alu_fn = a + b;
            4'b0110: alu_fn = a - b;
            4'b0111: alu_fn = b;
            4'b1100: alu_fn = ~(a | b);
            default: alu_fn = 64'hDEAD_BEEF_0BAD_F00D;
        endcase
    endfunction

    assign alu_result[0] = alu_fn(alu_ctl[0], alu_a[0], alu_b[0]);
    assign alu_zero[0]   = (alu_result[0] == 64'd0);
    assign alu_result[1] = alu_fn(alu_ctl[1], alu_a[1], alu_b[1]);
    assign alu_zero[1]   = (alu_result[1] == 64'd0);

    // Reference: operation meaning straight from the opcode, {illegal, result}.
    function automatic logic [64:0] ref_op(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            OP_AND:  ref_op = {1'b0, a & b};
            OP_ORR:  ref_op = {1'b0, a | b};
            OP_ADD:  ref_op = {1'b0, a + b};
            OP_SUB:  ref_op = {1'b0, a - b};
            OP_PSB:  ref_op = {1'b0, b};
            OP_NOR:  ref_op = {1'b0, ~(a | b)};
            default: ref_op = {1'b1, 64'd0};
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int k, input int id, input logic v, input logic [10:0] op,
                           input logic [63:0] a, input logic [63:0] b);
        if (id == 0) begin
            req0_valid[k] = v; req0_opcode[k] = op; req0_a[k] = a; req0_b[k] = b;
        end else begin
            req1_valid[k] = v; req1_opcode[k] = op; req1_a[k] = a; req1_b[k] = b;
        end
    endtask

    function automatic logic get_ready(input int k, input int id);
        return (id == 0) ? req0_ready[k] : req1_ready[k];
    endfunction

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            set_req(k, 0, 1'b0, '0, '0, '0);
            set_req(k, 1, 1'b0, '0, '0, '0);
            rsp_ready[k] = 1'b1;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic run_vec(input vec_t v);
        int k, lat, c, w, ctl_cnt, bad_ctl;
        k = v.inst;
        lat = v.ill ? 1 : ((k == 0) ? 1 : 3) + 1;
        rsp_ready[k] = 1'b1;
        set_req(k, v.id, 1'b1, v.op, v.a, v.b);
        #1;
        w = 0;
        while (!get_ready(k, v.id) && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check("vec_accept", {63'd0, get_ready(k, v.id)}, 64'd1);
        check("vec_other_ready", {63'd0, get_ready(k, 1 - int'(v.id))}, 64'd0);
        @(posedge clk); #1;
        set_req(k, v.id, 1'b0, '0, '0, '0);
        c = 1; ctl_cnt = 0; bad_ctl = 0;
        while (!rsp_valid[k] && c < 40) begin
            if (alu_ctl[k] == v.ctl) ctl_cnt++;
            else bad_ctl++;
            @(posedge clk); #1; c++;
        end
        check("vec_latency", c, lat);
        check("vec_exec_cycles", ctl_cnt, v.ill ? 0 : lat - 1);
        check("vec_bad_ctl", bad_ctl, 0);
        check("vec_rsp_ctl_idle", alu_ctl[k], 4'b0000);
        check("vec_rsp_id", rsp_id[k], v.id);
        check("vec_rsp_result", rsp_result[k], v.res);
        check("vec_rsp_zero", rsp_zero[k], v.zero);
        check("vec_rsp_illegal", rsp_illegal[k], v.ill);
        @(posedge clk); #1;
        check("vec_rsp_drop", rsp_valid[k], 1'b0);
    endtask

    task automatic rand_op(output logic [10:0] op, output logic [63:0] a, output logic [63:0] b);
        int sel;
        sel = $urandom_range(0, 7);
        op = (sel < 6) ? legal_ops[sel] : 11'($urandom);
        a = {$urandom, $urandom};
        b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
    endtask

    task automatic run_random(input int k, input int lat, input int n);
        logic        pv[2];
        logic [10:0] pop[2];
        logic [63:0] pa[2], pb[2];
        logic [64:0] r;
        logic        m_idle, m_resp, m_last, m_id, m_zero, m_ill;
        logic [63:0] m_res;
        int          m_cnt, g;
        m_idle = 1'b1; m_resp = 1'b0; m_last = 1'b1; m_cnt = 0;
        m_id = 1'b0; m_zero = 1'b0; m_ill = 1'b0; m_res = '0;
        for (int id = 0; id < 2; id++) begin
            pv[id] = 1'b0; pop[id] = '0; pa[id] = '0; pb[id] = '0;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            g = -1;
            if (m_idle) begin
                if (pv[0] && pv[1]) g = m_last ? 0 : 1;
                else if (pv[0])     g = 0;
                else if (pv[1])     g = 1;
            end
            check("rnd_ready0", req0_ready[k], g == 0);
            check("rnd_ready1", req1_ready[k], g == 1);
            check("rnd_busy", busy[k], !m_idle);
            check("rnd_rsp_valid", rsp_valid[k], m_resp);
            if (m_resp) begin
                check("rnd_rsp_id", rsp_id[k], m_id);
                check("rnd_rsp_result", rsp_result[k], m_res);
                check("rnd_rsp_zero", rsp_zero[k], m_zero);
                check("rnd_rsp_illegal", rsp_illegal[k], m_ill);
            end
            if (g >= 0) begin
                r = ref_op(pop[g], pa[g], pb[g]);
                m_ill = r[64]; m_res = r[63:0];
                m_zero = !m_ill && (m_res == 64'd0);
                m_id = g[0]; m_last = g[0]; m_idle = 1'b0;
                m_cnt = m_ill ? 0 : lat;
                m_resp = m_ill;
            end else if (!m_idle && !m_resp) begin
                m_cnt--;
                if (m_cnt == 0) m_resp = 1'b1;
            end else if (m_resp && rsp_ready[k]) begin
                m_resp = 1'b0; m_idle = 1'b1;
            end
            @(posedge clk); #1;
            for (int id = 0; id < 2; id++) begin
                if (g == id) begin
                    pv[id] = ($urandom_range(0, 3) != 0);
                    if (pv[id]) rand_op(pop[id], pa[id], pb[id]);
                end else if (pv[id]) begin
                    if ($urandom_range(0, 7) == 0) pv[id] = 1'b0;
                end else begin
                    pv[id] = ($urandom_range(0, 1) == 1);
                    if (pv[id]) rand_op(pop[id], pa[id], pb[id]);
                end
                set_req(k, id, pv[id], pop[id], pa[id], pb[id]);
            end
            rsp_ready[k] = ($urandom_range(0, 3) != 0);
        end
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, cyc, last, gid;
        logic [63:0] held_res;
        legal_ops[0] = OP_AND; legal_ops[1] = OP_ORR; legal_ops[2] = OP_ADD;
        legal_ops[3] = OP_SUB; legal_ops[4] = OP_PSB; legal_ops[5] = OP_NOR;
        vecs[0] = '{0, 1'b0, OP_ADD, 64'd5, 64'd3, 4'b0010, 64'd8, 1'b0, 1'b0};
        vecs[1] = '{0, 1'b0, OP_AND, 64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA, 4'b0000, 64'd0, 1'b1, 1'b0};
        vecs[2] = '{0, 1'b1, 11'b00000000000, 64'd9, 64'd9, 4'b0000, 64'd0, 1'b0, 1'b1};
        vecs[3] = '{1, 1'b0, OP_SUB, 64'd10, 64'd10, 4'b0110, 64'd0, 1'b1, 1'b0};
        vecs[4] = '{0, 1'b1, OP_ORR, 64'h5, 64'hA, 4'b0001, 64'hF, 1'b0, 1'b0};
        vecs[5] = '{0, 1'b0, OP_PSB, 64'd7, 64'h1234, 4'b0111, 64'h1234, 1'b0, 1'b0};
        vecs[6] = '{0, 1'b1, OP_NOR, 64'd0, 64'd0, 4'b1100, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0};
        vecs[7] = '{1, 1'b1, OP_ADD, 64'hFFFFFFFFFFFFFFFF, 64'd1, 4'b0010, 64'd0, 1'b1, 1'b0};
        vecs[8] = '{0, 1'b0, 11'b10001011001, 64'd1, 64'd2, 4'b0000, 64'd0, 1'b0, 1'b1};

        clear_inputs();
        #3;
        for (int k = 0; k < 2; k++) begin
            check("rst_busy", busy[k], 1'b0);
            check("rst_rsp_valid", rsp_valid[k], 1'b0);
            check("rst_alu_ctl", alu_ctl[k], 4'b0000);
            check("rst_alu_a", alu_a[k], 64'd0);
            check("rst_alu_b", alu_b[k], 64'd0);
            check("rst_rsp_result", rsp_result[k], 64'd0);
            check("rst_rsp_flags", {rsp_id[k], rsp_zero[k], rsp_illegal[k]}, 3'b000);
        end
        do_reset();

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Both requesters held valid: grants alternate, one op per ALU_LAT+2 cycles.
        do_reset();
        set_req(0, 0, 1'b1, OP_ADD, 64'd1, 64'd1);
        set_req(0, 1, 1'b1, OP_ADD, 64'd2, 64'd2);
        #1;
        cyc = 0; last = 0;
        for (int n = 0; n < 8; n++) begin
            w = 0;
            while (!(req0_ready[0] || req1_ready[0]) && w < 20) begin
                @(posedge clk); #1; w++; cyc++;
            end
            check("rr_wait", w < 20, 1'b1);
            check("rr_single", req0_ready[0] && req1_ready[0], 1'b0);
            gid = req1_ready[0] ? 1 : 0;
            check("rr_grant", gid, n % 2);
            if (n > 0) check("rr_gap", cyc - last, 3);
            last = cyc;
            @(posedge clk); #1; cyc++;
        end
        clear_inputs();

        // Response held under backpressure while req0 keeps asking.
        do_reset();
        rsp_ready[0] = 1'b0;
        set_req(0, 0, 1'b1, OP_ADD, 64'd7, 64'd8);
        #1;
        check("bp_accept", req0_ready[0], 1'b1);
        @(posedge clk); #1;
        set_req(0, 0, 1'b1, OP_SUB, 64'd3, 64'd1);
        w = 0;
        while (!rsp_valid[0] && w < 20) begin
            @(posedge clk); #1; w++;
        end
        held_res = rsp_result[0];
        check("bp_result", held_res, 64'd15);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_held", rsp_valid[0], 1'b1);
            check("bp_result_held", rsp_result[0], 64'd15);
            check("bp_flags_held", {rsp_id[0], rsp_zero[0], rsp_illegal[0]}, 3'b000);
            check("bp_ready_low", req0_ready[0], 1'b0);
            @(posedge clk); #1;
        end
        rsp_ready[0] = 1'b1;
        #1;
        check("bp_ready_hs", req0_ready[0], 1'b0);
        @(posedge clk); #1;
        check("bp_rsp_drop", rsp_valid[0], 1'b0);
        check("bp_ready_after", req0_ready[0], 1'b1);
        set_req(0, 0, 1'b0, '0, '0, '0);
        @(posedge clk); #2;

        // Asynchronous reset while the ALU_LAT=3 instance is executing.
        set_req(1, 0, 1'b1, OP_SUB, 64'd10, 64'd10);
        #1;
        w = 0;
        while (!req0_ready[1] && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check("rst_exec_accept", req0_ready[1], 1'b1);
        @(posedge clk); #1;
        set_req(1, 0, 1'b0, '0, '0, '0);
        check("rst_exec_ctl", alu_ctl[1], 4'b0110);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_busy", busy[1], 1'b0);
        check("rst_mid_rsp_valid", rsp_valid[1], 1'b0);
        check("rst_mid_ctl", alu_ctl[1], 4'b0000);
        check("rst_mid_alu_a", alu_a[1], 64'd0);
        @(posedge clk); #2 reset_n = 1'b1;
        @(posedge clk); #2;
        check("rst_after_rsp", rsp_valid[1], 1'b0);
        run_vec('{1, 1'b1, OP_ORR, 64'h5, 64'hA, 4'b0001, 64'hF, 1'b0, 1'b0});

        do_reset();
        run_random(0, 1, 400);
        do_reset();
        run_random(1, 3, 400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
